ef_pwm32_capture: RTL and testbench

//  PWM decoder: measures period and high time of an external PWM waveform, e.g. one driven by
//  ef_pwm32 pwmA/pwmB. Sits behind an APB register wrapper that exposes the results.

---
 rtl/ef_pwm32_capture_pkg.sv | 18 +
 rtl/ef_pwm32_capture_edge_sync.sv | 32 +++
 rtl/ef_pwm32_capture.sv | 142 ++++++++++++++
 tb/tb_ef_pwm32_capture.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ef_pwm32_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding and prescaler width.
// Also imported by the APB register wrapper and the bench.
package ef_pwm32_capture_pkg;

    localparam int unsigned CLKDIV_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } cap_state_e;

    function automatic logic is_busy(input cap_state_e s);
        return (s == ST_HIGH) || (s == ST_LOW);
    endfunction

endpackage

// File: rtl/ef_pwm32_capture_edge_sync.sv
// Synchronises the asynchronous PWM input, applies optional inversion and
// produces single-cycle rise/fall strobes one flop after the synchroniser.
module ef_pwm32_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    input  logic inv,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            lvl_q  <= lvl;
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1] ^ inv;
    assign rise = lvl & ~lvl_q;
    assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/ef_pwm32_capture.sv
// PWM decoder: measures period (rise to rise) and high time of an external
// PWM waveform in prescaled ticks, with timeout and enable abort.
module ef_pwm32_capture
    import ef_pwm32_capture_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in,
    input  logic                en,
    input  logic                inv,
    input  logic [CLKDIV_W-1:0] clkdiv,
    input  logic [WIDTH-1:0]    timeout,
    output logic [WIDTH-1:0]    period,
    output logic [WIDTH-1:0]    high_time,
    output logic                valid,
    output logic                ovf,
    output logic                busy
);

    localparam logic [CLKDIV_W-1:0] PRE_ONE = {{(CLKDIV_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]    CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic lvl, rise, fall;

    ef_pwm32_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .inv    (inv),
        .lvl    (lvl),
        .rise   (rise),
        .fall   (fall)
    );

    cap_state_e          state_q, state_d;
    logic [CLKDIV_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    period_q, period_d;
    logic [WIDTH-1:0]    high_q, high_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;

    logic                tick;
    logic [WIDTH-1:0]    cnt_cur;
    logic                to_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pre_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tick = (pre_q == clkdiv);

    // cnt_cur includes this cycle's tick, so an edge H clk after the rise reads H at clkdiv=0.
    assign cnt_cur = (tick && (cnt_q != '1)) ? cnt_q + CNT_ONE : cnt_q;
    assign to_hit  = (timeout != '0) && (cnt_cur >= timeout);

    always_comb begin
        state_d  = state_q;
        pre_d    = tick ? '0 : pre_q + PRE_ONE;
        cnt_d    = cnt_cur;
        hi_d     = hi_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        ovf_d    = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    pre_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        pre_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        hi_d    = cnt_cur;
                        state_d = ST_LOW;
                    end else if (to_hit && lvl) begin
                        ovf_d   = 1'b1;
                        state_d = ST_ARM;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_d = cnt_cur;
                        high_d   = hi_q;
                        valid_d  = 1'b1;
                        pre_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_HIGH;
                    end else if (to_hit && !lvl) begin
                        ovf_d   = 1'b1;
                        state_d = ST_ARM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign ovf       = ovf_q;
    assign busy      = is_busy(state_q);

endmodule

// File: tb/tb_ef_pwm32_capture.sv
// Directed bench for ef_pwm32_capture (WIDTH=8 so saturation is reachable quickly).
module tb_ef_pwm32_capture;
    import ef_pwm32_capture_pkg::*;

    localparam int unsigned W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                pwm_in = 1'b0;
    logic                en = 1'b0;
    logic                inv = 1'b0;
    logic [CLKDIV_W-1:0] clkdiv = '0;
    logic [W-1:0]        timeout = '0;
    logic [W-1:0]        period, high_time;
    logic                valid, ovf, busy;

    ef_pwm32_capture #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .en        (en),
        .inv       (inv),
        .clkdiv    (clkdiv),
        .timeout   (timeout),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampling on the falling edge.
    int       nvalid = 0, novf = 0, vcyc_prev = 0, vgap = 0, ovf_cyc = 0, busy_cyc = 0;
    logic     busy_prev = 1'b0;
    logic [W-1:0] vperiod = '0, vhigh = '0;
    always @(negedge clk) begin
        if (valid) begin
            nvalid++;
            vperiod = period;
            vhigh = high_time;
            vgap = cyc - vcyc_prev;
            vcyc_prev = cyc;
        end
        if (ovf) begin
            novf++;
            ovf_cyc = cyc;
        end
        if (busy && !busy_prev) busy_cyc = cyc;
        busy_prev = busy;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pwm_periods(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            step(h);
            pwm_in = 1'b0;
            step(p - h);
        end
    endtask

    task automatic restart(input logic [CLKDIV_W-1:0] cd, input logic iv, input logic [W-1:0] to);
        en = 1'b0;
        pwm_in = 1'b0;
        inv = iv;
        clkdiv = cd;
        timeout = to;
        step(6);
        en = 1'b1;
        step(2);
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        n_checks++; if (period !== 8'd0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period); end
        n_checks++; if (high_time !== 8'd0) begin n_fail++; $display("FAIL reset_high: got %0d expected 0", high_time); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_basic;
        int v0, o0;
        restart(4'd0, 1'b0, 8'd0);
        v0 = nvalid; o0 = novf;
        pwm_periods(100, 30, 5);
        pwm_in = 1'b1;
        step(6);
        n_checks++; if (nvalid - v0 !== 5) begin n_fail++; $display("FAIL basic_count: got %0d expected 5", nvalid - v0); end
        n_checks++; if (vperiod !== 8'd100) begin n_fail++; $display("FAIL basic_period: got %0d expected 100", vperiod); end
        n_checks++; if (vhigh !== 8'd30) begin n_fail++; $display("FAIL basic_high: got %0d expected 30", vhigh); end
        n_checks++; if (vgap !== 100) begin n_fail++; $display("FAIL basic_gap: got %0d expected 100", vgap); end
        n_checks++; if (novf - o0 !== 0) begin n_fail++; $display("FAIL basic_ovf: got %0d expected 0", novf - o0); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    endtask

    task automatic test_prescale;
        int v0;
        restart(4'd3, 1'b0, 8'd0);
        v0 = nvalid;
        pwm_periods(400, 100, 4);
        pwm_in = 1'b1;
        step(6);
        n_checks++; if (nvalid - v0 !== 4) begin n_fail++; $display("FAIL pre_count: got %0d expected 4", nvalid - v0); end
        n_checks++; if (vperiod !== 8'd100) begin n_fail++; $display("FAIL pre_period: got %0d expected 100", vperiod); end
        n_checks++; if (vhigh !== 8'd25) begin n_fail++; $display("FAIL pre_high: got %0d expected 25", vhigh); end
        n_checks++; if (vgap !== 400) begin n_fail++; $display("FAIL pre_gap: got %0d expected 400", vgap); end
    endtask

    task automatic test_invert;
        int v0;
        restart(4'd0, 1'b1, 8'd0);
        v0 = nvalid;
        pwm_periods(100, 30, 5);
        step(6);
        n_checks++; if (nvalid - v0 !== 4) begin n_fail++; $display("FAIL inv_count: got %0d expected 4", nvalid - v0); end
        n_checks++; if (vperiod !== 8'd100) begin n_fail++; $display("FAIL inv_period: got %0d expected 100", vperiod); end
        n_checks++; if (vhigh !== 8'd70) begin n_fail++; $display("FAIL inv_high: got %0d expected 70", vhigh); end
    endtask

    task automatic test_timeout;
        int v0, o0;
        restart(4'd0, 1'b0, 8'd50);
        v0 = nvalid; o0 = novf;
        pwm_in = 1'b1;
        step(80);
        n_checks++; if (novf - o0 !== 1) begin n_fail++; $display("FAIL to_ovf_count: got %0d expected 1", novf - o0); end
        n_checks++; if (ovf_cyc - busy_cyc !== 50) begin n_fail++; $display("FAIL to_ovf_delay: got %0d expected 50", ovf_cyc - busy_cyc); end
        n_checks++; if (nvalid - v0 !== 0) begin n_fail++; $display("FAIL to_valid: got %0d expected 0", nvalid - v0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy_arm: got %b expected 0", busy); end
        n_checks++; if (period !== 8'd100) begin n_fail++; $display("FAIL to_period_hold: got %0d expected 100", period); end
        n_checks++; if (high_time !== 8'd70) begin n_fail++; $display("FAIL to_high_hold: got %0d expected 70", high_time); end

        restart(4'd0, 1'b0, 8'd0);
        v0 = nvalid; o0 = novf;
        pwm_in = 1'b1;
        step(300);
        pwm_in = 1'b0;
        step(10);
        pwm_in = 1'b1;
        step(6);
        n_checks++; if (novf - o0 !== 0) begin n_fail++; $display("FAIL sat_ovf: got %0d expected 0", novf - o0); end
        n_checks++; if (nvalid - v0 !== 1) begin n_fail++; $display("FAIL sat_count: got %0d expected 1", nvalid - v0); end
        n_checks++; if (vhigh !== 8'd255) begin n_fail++; $display("FAIL sat_high: got %0d expected 255", vhigh); end
        n_checks++; if (vperiod !== 8'd255) begin n_fail++; $display("FAIL sat_period: got %0d expected 255", vperiod); end
    endtask

    task automatic test_abort;
        int v0, v1;
        restart(4'd0, 1'b0, 8'd0);
        v0 = nvalid;
        pwm_periods(100, 30, 2);
        pwm_in = 1'b1;
        step(30);
        pwm_in = 1'b0;
        step(20);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_low: got %b expected 1", busy); end
        en = 1'b0;
        step(1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_off: got %b expected 0", busy); end
        step(40);
        n_checks++; if (nvalid - v0 !== 2) begin n_fail++; $display("FAIL abort_count: got %0d expected 2", nvalid - v0); end
        en = 1'b1;
        step(10);
        v1 = nvalid;
        pwm_periods(100, 30, 1);
        n_checks++; if (nvalid - v1 !== 0) begin n_fail++; $display("FAIL abort_first_rise: got %0d expected 0", nvalid - v1); end
        pwm_in = 1'b1;
        step(6);
        n_checks++; if (nvalid - v1 !== 1) begin n_fail++; $display("FAIL abort_rearm_count: got %0d expected 1", nvalid - v1); end
        n_checks++; if (vperiod !== 8'd100) begin n_fail++; $display("FAIL abort_period: got %0d expected 100", vperiod); end
        n_checks++; if (vhigh !== 8'd30) begin n_fail++; $display("FAIL abort_high: got %0d expected 30", vhigh); end
    endtask

    task automatic test_back_to_back;
        int v0, o0;
        restart(4'd0, 1'b0, 8'd100);
        v0 = nvalid; o0 = novf;
        pwm_periods(100, 30, 3);
        pwm_in = 1'b1;
        step(6);
        n_checks++; if (nvalid - v0 !== 3) begin n_fail++; $display("FAIL edge_to_count: got %0d expected 3", nvalid - v0); end
        n_checks++; if (novf - o0 !== 0) begin n_fail++; $display("FAIL edge_to_ovf: got %0d expected 0", novf - o0); end
        n_checks++; if (vperiod !== 8'd100) begin n_fail++; $display("FAIL edge_to_period: got %0d expected 100", vperiod); end
    endtask

    task automatic test_rst_mid;
        restart(4'd0, 1'b0, 8'd0);
        pwm_in = 1'b1;
        step(10);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (period !== 8'd0) begin n_fail++; $display("FAIL rst_mid_period: got %0d expected 0", period); end
        n_checks++; if (high_time !== 8'd0) begin n_fail++; $display("FAIL rst_mid_high: got %0d expected 0", high_time); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_checks++; if (valid !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulses: got %b%b expected 00", valid, ovf); end
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescale();
        test_invert();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
